// File: rtl/spram_phase_initiator.sv
// Two-phase initiator for the shared single-port RAM: phase strobes plus per-phase bus, c1 on phase 1, c2 on phase 2.
// Latency: ack in the phN_en cycle, read data with rvalid HALF+1 cycles after ack.
// Backpressure: req is held until ack; optional RAM_SEQ_RDATA_HOLD_EN registers rdata and holds it between rvalids.
module spram_phase_initiator #(
    parameter int AW   = 10,
    parameter int DW   = 32,
    parameter int HALF = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c1_req,
    output logic          c1_ack,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_rvalid,
    output logic [DW-1:0] c1_rdata,
    input  logic          c2_req,
    output logic          c2_ack,
    input  logic          c2_we,
    input  logic [AW-1:0] c2_addr,
    input  logic [DW-1:0] c2_wdata,
    output logic          c2_rvalid,
    output logic [DW-1:0] c2_rdata,
    output logic          ph1_en,
    output logic [AW-1:0] ph1_addr,
    output logic [DW-1:0] ph1_di,
    output logic          ph1_we,
    input  logic [DW-1:0] ph1_do,
    output logic          ph2_en,
    output logic [AW-1:0] ph2_addr,
    output logic [DW-1:0] ph2_di,
    output logic          ph2_we,
    input  logic [DW-1:0] ph2_do
);
    localparam int PER = 2 * HALF;
    localparam int CW  = (PER > 2) ? $clog2(PER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PER - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    generate
        if (HALF < 2) begin : g_half_check
            $error("spram_phase_initiator: HALF must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ph1_en_q, ph1_en_d, ph2_en_q, ph2_en_d;
    logic [AW-1:0] ph1_addr_q, ph1_addr_d, ph2_addr_q, ph2_addr_d;
    logic [DW-1:0] ph1_di_q, ph1_di_d, ph2_di_q, ph2_di_d;
    logic          ph1_we_q, ph1_we_d, ph2_we_q, ph2_we_d;
    logic          rdpend1_q, rdpend1_d, rdpend2_q, rdpend2_d;
    logic          c1_rvalid_q, c1_rvalid_d, c2_rvalid_q, c2_rvalid_d;

    always_comb begin
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        ph1_en_d    = (cnt_q == CNT_LAST);
        ph2_en_d    = (cnt_q == CNT_MID);
        ph1_addr_d  = ph1_addr_q;
        ph1_di_d    = ph1_di_q;
        ph1_we_d    = ph1_we_q;
        rdpend1_d   = rdpend1_q;
        ph2_addr_d  = ph2_addr_q;
        ph2_di_d    = ph2_di_q;
        ph2_we_d    = ph2_we_q;
        rdpend2_d   = rdpend2_q;
        c1_rvalid_d = ph2_en_q & rdpend1_q;
        c2_rvalid_d = ph1_en_q & rdpend2_q;
        // An empty slot becomes a dummy read of the previous address.
        if (ph1_en_q) begin
            ph1_we_d  = c1_req & c1_we;
            rdpend1_d = c1_req & ~c1_we;
            if (c1_req) begin
                ph1_addr_d = c1_addr;
                ph1_di_d   = c1_wdata;
            end
        end
        if (ph2_en_q) begin
            ph2_we_d  = c2_req & c2_we;
            rdpend2_d = c2_req & ~c2_we;
            if (c2_req) begin
                ph2_addr_d = c2_addr;
                ph2_di_d   = c2_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            ph1_en_q    <= 1'b0;
            ph2_en_q    <= 1'b0;
            ph1_addr_q  <= '0;
            ph1_di_q    <= '0;
            ph1_we_q    <= 1'b0;
            ph2_addr_q  <= '0;
            ph2_di_q    <= '0;
            ph2_we_q    <= 1'b0;
            rdpend1_q   <= 1'b0;
            rdpend2_q   <= 1'b0;
            c1_rvalid_q <= 1'b0;
            c2_rvalid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ph1_en_q    <= ph1_en_d;
            ph2_en_q    <= ph2_en_d;
            ph1_addr_q  <= ph1_addr_d;
            ph1_di_q    <= ph1_di_d;
            ph1_we_q    <= ph1_we_d;
            ph2_addr_q  <= ph2_addr_d;
            ph2_di_q    <= ph2_di_d;
            ph2_we_q    <= ph2_we_d;
            rdpend1_q   <= rdpend1_d;
            rdpend2_q   <= rdpend2_d;
            c1_rvalid_q <= c1_rvalid_d;
            c2_rvalid_q <= c2_rvalid_d;
        end
    end

`ifdef RAM_SEQ_RDATA_HOLD_EN
    logic [DW-1:0] c1_rdata_q, c1_rdata_d, c2_rdata_q, c2_rdata_d;

    always_comb begin
        c1_rdata_d = c1_rvalid_d ? ph1_do : c1_rdata_q;
        c2_rdata_d = c2_rvalid_d ? ph2_do : c2_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_rdata_q <= '0;
            c2_rdata_q <= '0;
        end else begin
            c1_rdata_q <= c1_rdata_d;
            c2_rdata_q <= c2_rdata_d;
        end
    end

    assign c1_rdata = c1_rdata_q;
    assign c2_rdata = c2_rdata_q;
`else
    assign c1_rdata = c1_rvalid_q ? ph1_do : '0;
    assign c2_rdata = c2_rvalid_q ? ph2_do : '0;
`endif

    assign c1_ack    = ph1_en_q & c1_req;
    assign c2_ack    = ph2_en_q & c2_req;
    assign c1_rvalid = c1_rvalid_q;
    assign c2_rvalid = c2_rvalid_q;
    assign ph1_en    = ph1_en_q;
    assign ph1_addr  = ph1_addr_q;
    assign ph1_di    = ph1_di_q;
    assign ph1_we    = ph1_we_q;
    assign ph2_en    = ph2_en_q;
    assign ph2_addr  = ph2_addr_q;
    assign ph2_di    = ph2_di_q;
    assign ph2_we    = ph2_we_q;

endmodule

// File: tb/tb_spram_phase_initiator.sv
// Directed bench for spram_phase_initiator with a behavioural two-phase RAM that
// executes each phase operation on the edge after its strobe.
module tb_spram_phase_initiator;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c1_req = 0, c1_we = 0, c2_req = 0, c2_we = 0;
    logic [AW-1:0] c1_addr = '0, c2_addr = '0;
    logic [DW-1:0] c1_wdata = '0, c2_wdata = '0;
    logic          c1_ack, c2_ack, c1_rvalid, c2_rvalid;
    logic [DW-1:0] c1_rdata, c2_rdata;
    logic          ph1_en, ph2_en, ph1_we, ph2_we;
    logic [AW-1:0] ph1_addr, ph2_addr;
    logic [DW-1:0] ph1_di, ph2_di;
    logic [DW-1:0] ph1_do = '0, ph2_do = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv1_n = 0, rv2_n = 0, rv1_cyc = 0, rv2_cyc = 0;
    logic [DW-1:0] rv1_dat = '0, rv2_dat = '0;

`ifdef RAM_SEQ_RDATA_HOLD_EN
    localparam logic [DW-1:0] IDLE_RDATA = 32'hDEADBEEF;
`else
    localparam logic [DW-1:0] IDLE_RDATA = 32'h0;
`endif

    spram_phase_initiator #(.AW(AW), .DW(DW), .HALF(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c1_req(c1_req), .c1_ack(c1_ack), .c1_we(c1_we), .c1_addr(c1_addr),
        .c1_wdata(c1_wdata), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .c2_req(c2_req), .c2_ack(c2_ack), .c2_we(c2_we), .c2_addr(c2_addr),
        .c2_wdata(c2_wdata), .c2_rvalid(c2_rvalid), .c2_rdata(c2_rdata),
        .ph1_en(ph1_en), .ph1_addr(ph1_addr), .ph1_di(ph1_di), .ph1_we(ph1_we), .ph1_do(ph1_do),
        .ph2_en(ph2_en), .ph2_addr(ph2_addr), .ph2_di(ph2_di), .ph2_we(ph2_we), .ph2_do(ph2_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          ph1_en_d = 1'b0, ph2_en_d = 1'b0;
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    always @(posedge clk) begin
        ph1_en_d <= ph1_en;
        ph2_en_d <= ph2_en;
        if (ph1_en_d) begin
            if (ph1_we) mem[ph1_addr] <= ph1_di;
            else        ph1_do <= mem[ph1_addr];
        end
        if (ph2_en_d) begin
            if (ph2_we) mem[ph2_addr] <= ph2_di;
            else        ph2_do <= mem[ph2_addr];
        end
    end

    always @(negedge clk) begin
        if (c1_rvalid) begin rv1_n++; rv1_cyc = cyc; rv1_dat = c1_rdata; end
        if (c2_rvalid) begin rv2_n++; rv2_cyc = cyc; rv2_dat = c2_rdata; end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 of the cycle after ack with req dropped.
    task automatic issue(input int n, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int ack_at);
        bit got = 0;
        ack_at = -1;
        if (n == 1) begin c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = d; end
        else        begin c2_req = 1; c2_we = we; c2_addr = a; c2_wdata = d; end
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if ((n == 1) ? c1_ack : c2_ack) begin got = 1; ack_at = cyc; end
            else @(posedge clk);
        end
        check($sformatf("ack_seen_c%0d", n), 64'(got), 64'd1);
        step();
        if (n == 1) c1_req = 0; else c2_req = 0;
    endtask

    task automatic wait_strobe(input int n);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if ((n == 1) ? ph1_en : ph2_en) got = 1;
            else step();
        end
        check($sformatf("strobe_seen_ph%0d", n), 64'(got), 64'd1);
    endtask

    // Waits for the next rvalid of client n, then realigns to posedge+1 of the following cycle.
    task automatic read_check(input string tag, input int n, input int ack_at, input logic [DW-1:0] exp);
        int base = (n == 1) ? rv1_n : rv2_n;
        for (int k = 0; k < 16 && ((n == 1) ? rv1_n : rv2_n) == base; k++) @(negedge clk);
        check({tag, "_rvcount"}, 64'((n == 1) ? rv1_n - base : rv2_n - base), 64'd1);
        check({tag, "_latency"}, 64'((n == 1) ? rv1_cyc - ack_at : rv2_cyc - ack_at), 64'd5);
        check({tag, "_rdata"}, 64'((n == 1) ? rv1_dat : rv2_dat), 64'(exp));
        step();
    endtask

    initial begin
        int a, b, c, raise, n0;
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, raise, n0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ph1_en", 64'(ph1_en), 64'd0);
        check("rst_ph2_en", 64'(ph2_en), 64'd0);
        check("rst_ph1_we", 64'(ph1_we), 64'd0);
        check("rst_ph1_addr", 64'(ph1_addr), 64'd0);
        check("rst_ph2_di", 64'(ph2_di), 64'd0);
        check("rst_rvalid", 64'({c1_rvalid, c2_rvalid}), 64'd0);
        check("rst_c1_rdata", 64'(c1_rdata), 64'd0);
        rst_n = 1;

        // Strobe cadence: ph1 at cycles 8,16,24; ph2 at 4,12,20.
        for (int i = 1; i <= 24; i++) begin
            step();
            check($sformatf("cad_ph1_c%0d", i), 64'(ph1_en), 64'(i % 8 == 0));
            check($sformatf("cad_ph2_c%0d", i), 64'(ph2_en), 64'(i % 8 == 4));
        end

        // Write then read back on client 1; the write must not raise rvalid.
        n0 = rv1_n;
        issue(1, 1'b1, 10'h010, 32'hDEADBEEF, a);
        issue(1, 1'b0, 10'h010, 32'h0, b);
        check("t2_ack_spacing", 64'(b - a), 64'd8);
        read_check("t2_rd", 1, b, 32'hDEADBEEF);
        check("t2_no_write_rvalid", 64'(rv1_n - n0), 64'd1);
        check("t2_rvalid_pulse", 64'(c1_rvalid), 64'd0);
        check("t2_idle_rdata", 64'(c1_rdata), 64'(IDLE_RDATA));

        // Phase-1 write seen by the next phase-2 read; concurrent phase-2 write elsewhere.
        wait_strobe(2);
        fork
            issue(2, 1'b1, 10'h030, 32'h5A5A5A5A, a);
            issue(1, 1'b1, 10'h020, 32'h11111111, b);
        join
        check("t3_c1_after_c2", 64'(b - a), 64'd4);
        issue(2, 1'b0, 10'h020, 32'h0, c);
        check("t3_next_ph2", 64'(c - b), 64'd4);
        read_check("t3_c2_rd20", 2, c, 32'h11111111);
        issue(1, 1'b0, 10'h030, 32'h0, a);
        read_check("t3_c1_rd30", 1, a, 32'h5A5A5A5A);
        issue(1, 1'b0, 10'h020, 32'h0, a);
        read_check("t3_c1_rd20", 1, a, 32'h11111111);

        // Request raised at cnt==1 waits for the next ph1_en; bus holds until then.
        wait_strobe(1);
        step();
        raise = cyc;
        fork
            issue(1, 1'b1, 10'h040, 32'hCAFEF00D, a);
            for (int i = 0; i < 7; i++) begin
                check($sformatf("t4_wait_ack_%0d", i), 64'(c1_ack), 64'd0);
                check($sformatf("t4_wait_addr_%0d", i), 64'(ph1_addr), 64'h020);
                check($sformatf("t4_wait_we_%0d", i), 64'(ph1_we), 64'd0);
                step();
            end
        join
        check("t4_ack_delay", 64'(a - raise), 64'd7);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_slot_we_%0d", i), 64'(ph1_we), 64'd1);
            check($sformatf("t4_slot_addr_%0d", i), 64'(ph1_addr), 64'h040);
            check($sformatf("t4_slot_di_%0d", i), 64'(ph1_di), 64'hCAFEF00D);
            step();
        end
        check("t4_idle_we", 64'(ph1_we), 64'd0);
        check("t4_idle_addr", 64'(ph1_addr), 64'h040);

        // Reset two cycles after a read ack discards the read.
        wait_strobe(2);
        fork
            issue(2, 1'b1, 10'h050, 32'h12345678, a);
            issue(1, 1'b0, 10'h010, 32'h0, b);
        join
        check("t5_ph2_we_before", 64'(ph2_we), 64'd1);
        n0 = rv1_n;
        step();
        rst_n = 0;
        #1;
        check("t5_ph1_we_rst", 64'(ph1_we), 64'd0);
        check("t5_ph2_we_rst", 64'(ph2_we), 64'd0);
        check("t5_ph1_en_rst", 64'(ph1_en), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("t5_ph1_en_c%0d", i), 64'(ph1_en), 64'(i == 8));
        end
        check("t5_no_rvalid", 64'(rv1_n - n0), 64'd0);
        check("t5_rdata_cleared", 64'(c1_rdata), 64'd0);
        issue(1, 1'b0, 10'h050, 32'h0, a);
        read_check("t5_recover_rd", 1, a, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
